// File: rtl/key_entry_ctrl.sv
// key_entry_ctrl: keypad HHMM entry sequencer for time/alarm loading (optional timeout via KEY_ENTRY_TIMEOUT_EN)
`ifndef KP_0
`define KP_0     8'h30
`define KP_1     8'h31
`define KP_2     8'h32
`define KP_3     8'h33
`define KP_4     8'h34
`define KP_5     8'h35
`define KP_6     8'h36
`define KP_7     8'h37
`define KP_8     8'h38
`define KP_9     8'h39
`define KP_STAR  8'h2A
`define KP_MINUS 8'h2D
`endif

module key_entry_ctrl #(
  parameter int TIMEOUT_TICKS = 1280,
  parameter int TMO_W         = 11
) (
  input  logic        clk256,
  input  logic        reset,
  input  logic [7:0]  key,
  output logic        entry_active,
  output logic        entry_alarm,
  output logic [2:0]  digit_cnt,
  output logic [15:0] entry_bcd,
  output logic [7:0]  hh_bcd,
  output logic [7:0]  mm_bcd,
  output logic        load_time,
  output logic        load_alarm,
  output logic        entry_err,
  output logic        entry_abort
);
  typedef enum logic [1:0] {S_IDLE, S_ENTRY, S_CHECK} state_t;

  if (2**TMO_W <= TIMEOUT_TICKS) begin : g_tmo_w_check
    $error("TMO_W too narrow for TIMEOUT_TICKS");
  end

  state_t      r_state, w_state_n;
  logic [7:0]  r_key_q;
  logic        r_entry_alarm, w_alarm_n;
  logic [2:0]  r_digit_cnt, w_cnt_n;
  logic [15:0] r_entry_bcd, w_bcd_n;
  logic [7:0]  r_hh, w_hh_n, r_mm, w_mm_n;
  logic        r_load_time, w_load_time_n;
  logic        r_load_alarm, w_load_alarm_n;
  logic        r_err, w_err_n;
  logic        w_press, w_digit, w_star, w_minus, w_cmd, w_valid, w_expire;
  logic [3:0]  w_d;

  assign w_press = (key != 8'd0) && (r_key_q == 8'd0);
  assign w_digit = (key >= `KP_0) && (key <= `KP_9);
  assign w_star  = key == `KP_STAR;
  assign w_minus = key == `KP_MINUS;
  assign w_cmd   = w_press && (w_star || w_minus);
  assign w_d     = 4'(key - `KP_0);
  assign w_valid = (r_entry_bcd[15:8] <= 8'h23) && (r_entry_bcd[7:0] <= 8'h59);

`ifdef KEY_ENTRY_TIMEOUT_EN
  logic [TMO_W-1:0] r_tmo;
  logic             r_abort;
  logic             w_acc;
  assign w_acc    = w_press && (w_digit || w_star || w_minus);
  assign w_expire = (r_state == S_ENTRY) && !w_acc && (r_tmo == TMO_W'(TIMEOUT_TICKS - 1));
  // Idle-time counter: held at 0 outside ENTRY and cleared by every accepted press
  always_ff @(posedge clk256 or posedge reset) begin
    if (reset) begin
      r_tmo   <= '0;
      r_abort <= 1'b0;
    end else begin
      r_tmo   <= (r_state != S_ENTRY || w_acc) ? '0 : r_tmo + 1'b1;
      r_abort <= w_expire;
    end
  end
  assign entry_abort = r_abort;
`else
  assign w_expire    = 1'b0;
  assign entry_abort = 1'b0;
`endif

  // State and datapath registers; key_q gives the edge-detected press
  always_ff @(posedge clk256 or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_key_q       <= 8'd0;
      r_entry_alarm <= 1'b0;
      r_digit_cnt   <= 3'd0;
      r_entry_bcd   <= 16'd0;
      r_hh          <= 8'd0;
      r_mm          <= 8'd0;
      r_load_time   <= 1'b0;
      r_load_alarm  <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_state       <= w_state_n;
      r_key_q       <= key;
      r_entry_alarm <= w_alarm_n;
      r_digit_cnt   <= w_cnt_n;
      r_entry_bcd   <= w_bcd_n;
      r_hh          <= w_hh_n;
      r_mm          <= w_mm_n;
      r_load_time   <= w_load_time_n;
      r_load_alarm  <= w_load_alarm_n;
      r_err         <= w_err_n;
    end
  end

  // Next state: '*'/'-' (re)start outside CHECK, digits collect in ENTRY, CHECK commits or flags in one cycle
  always_comb begin
    w_state_n      = r_state;
    w_alarm_n      = r_entry_alarm;
    w_cnt_n        = r_digit_cnt;
    w_bcd_n        = r_entry_bcd;
    w_hh_n         = r_hh;
    w_mm_n         = r_mm;
    w_load_time_n  = 1'b0;
    w_load_alarm_n = 1'b0;
    w_err_n        = 1'b0;
    if (r_state == S_CHECK) begin
      w_state_n      = S_IDLE;
      w_cnt_n        = 3'd0;
      w_hh_n         = w_valid ? r_entry_bcd[15:8] : r_hh;
      w_mm_n         = w_valid ? r_entry_bcd[7:0] : r_mm;
      w_load_alarm_n = w_valid && r_entry_alarm;
      w_load_time_n  = w_valid && !r_entry_alarm;
      w_err_n        = !w_valid;
    end else if (w_cmd) begin
      w_state_n = S_ENTRY;
      w_alarm_n = w_star;
      w_cnt_n   = 3'd0;
      w_bcd_n   = 16'd0;
    end else if (r_state == S_ENTRY && w_press && w_digit) begin
      w_bcd_n   = {r_entry_bcd[11:0], w_d};
      w_cnt_n   = r_digit_cnt + 3'd1;
      w_state_n = (r_digit_cnt == 3'd3) ? S_CHECK : S_ENTRY;
    end else if (w_expire) begin
      w_state_n = S_IDLE;
      w_cnt_n   = 3'd0;
    end
  end

  assign entry_active = r_state != S_IDLE;
  assign entry_alarm  = r_entry_alarm;
  assign digit_cnt    = r_digit_cnt;
  assign entry_bcd    = r_entry_bcd;
  assign hh_bcd       = r_hh;
  assign mm_bcd       = r_mm;
  assign load_time    = r_load_time;
  assign load_alarm   = r_load_alarm;
  assign entry_err    = r_err;
endmodule

// File: tb/tb_key_entry_ctrl.sv
// tb_key_entry_ctrl: directed self-checking bench for key_entry_ctrl
`timescale 1ns/1ps
`ifndef KP_0
`define KP_0     8'h30
`define KP_1     8'h31
`define KP_2     8'h32
`define KP_3     8'h33
`define KP_4     8'h34
`define KP_5     8'h35
`define KP_6     8'h36
`define KP_7     8'h37
`define KP_8     8'h38
`define KP_9     8'h39
`define KP_STAR  8'h2A
`define KP_MINUS 8'h2D
`endif

module tb_key_entry_ctrl;
  logic        clk256 = 1'b0;
  logic        reset  = 1'b1;
  logic [7:0]  key    = 8'd0;
  logic        entry_active, entry_alarm, load_time, load_alarm, entry_err, entry_abort;
  logic [2:0]  digit_cnt;
  logic [15:0] entry_bcd;
  logic [7:0]  hh_bcd, mm_bcd;
  int checks = 0;
  int errors = 0;
  int n_lt = 0, n_la = 0, n_err = 0, n_ab = 0;

  key_entry_ctrl dut (
    .clk256(clk256), .reset(reset), .key(key),
    .entry_active(entry_active), .entry_alarm(entry_alarm), .digit_cnt(digit_cnt),
    .entry_bcd(entry_bcd), .hh_bcd(hh_bcd), .mm_bcd(mm_bcd),
    .load_time(load_time), .load_alarm(load_alarm),
    .entry_err(entry_err), .entry_abort(entry_abort)
  );

  always #5 clk256 = ~clk256;

  always @(negedge clk256) begin
    n_lt  <= n_lt + int'(load_time);
    n_la  <= n_la + int'(load_alarm);
    n_err <= n_err + int'(entry_err);
    n_ab  <= n_ab + int'(entry_abort);
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [7:0] c);
    @(negedge clk256) key = c;
    @(negedge clk256) key = 8'd0;
  endtask

  task automatic entry(input logic [7:0] cmd, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] c, input logic [7:0] d);
    press(cmd); press(a); press(b); press(c); press(d);
  endtask

  task automatic settle();
    repeat (4) @(negedge clk256);
  endtask

  task automatic clr_counts();
    @(negedge clk256);
    n_lt = 0; n_la = 0; n_err = 0; n_ab = 0;
  endtask

  initial begin
    repeat (3) @(negedge clk256);
    chk("rst_active", {15'd0, entry_active}, 16'd0);
    chk("rst_bcd", entry_bcd, 16'd0);
    chk("rst_hhmm", {hh_bcd, mm_bcd}, 16'd0);
    chk("rst_strobes", {12'd0, load_time, load_alarm, entry_err, entry_abort}, 16'd0);
    chk("rst_cnt", {13'd0, digit_cnt}, 16'd0);
    reset = 1'b0;
    clr_counts();

    press(`KP_1);
    chk("idle_digit_ignored", {12'd0, entry_active, digit_cnt}, 16'd0);

    entry(`KP_MINUS, `KP_1, `KP_2, `KP_3, `KP_4);
    chk("t1_cnt4", {13'd0, digit_cnt}, 16'd4);
    chk("t1_not_yet", {15'd0, load_time}, 16'd0);
    @(negedge clk256);
    chk("t1_strobe", {15'd0, load_time}, 16'd1);
    chk("t1_hhmm", {hh_bcd, mm_bcd}, 16'h1234);
    chk("t1_idle", {12'd0, entry_active, digit_cnt}, 16'd0);
    settle();
    chk("t1_once", 16'(n_lt), 16'd1);
    chk("t1_no_alarm", 16'(n_la + n_err), 16'd0);

    clr_counts();
    entry(`KP_STAR, `KP_0, `KP_6, `KP_3, `KP_0);
    settle();
    chk("t2_la_once", 16'(n_la), 16'd1);
    chk("t2_no_lt", 16'(n_lt + n_err), 16'd0);
    chk("t2_hhmm", {hh_bcd, mm_bcd}, 16'h0630);
    chk("t2_alarm", {15'd0, entry_alarm}, 16'd1);

    clr_counts();
    entry(`KP_MINUS, `KP_2, `KP_4, `KP_0, `KP_0);
    settle();
    chk("t3_err_once", 16'(n_err), 16'd1);
    chk("t3_no_load", 16'(n_lt + n_la), 16'd0);
    chk("t3_hhmm_kept", {hh_bcd, mm_bcd}, 16'h0630);
    chk("t3_bcd_held", entry_bcd, 16'h2400);

    clr_counts();
    entry(`KP_MINUS, `KP_1, `KP_2, `KP_6, `KP_0);
    settle();
    chk("t3b_min_err", 16'(n_err), 16'd1);
    chk("t3b_hhmm_kept", {hh_bcd, mm_bcd}, 16'h0630);

    clr_counts();
    press(`KP_MINUS);
    @(negedge clk256) key = `KP_5;
    repeat (50) @(negedge clk256);
    key = 8'd0;
    chk("t4_held_cnt", {13'd0, digit_cnt}, 16'd1);
    chk("t4_held_bcd", entry_bcd, 16'h0005);
    press(`KP_MINUS); press(`KP_1);
    press(`KP_STAR);
    chk("t4_restart", {12'd0, entry_alarm, digit_cnt}, 16'h0008);
    press(`KP_2); press(`KP_3); press(`KP_5); press(`KP_9);
    settle();
    chk("t4_la_once", 16'(n_la), 16'd1);
    chk("t4_hhmm", {hh_bcd, mm_bcd}, 16'h2359);

    clr_counts();
    press(`KP_MINUS); press(`KP_1); press(`KP_2);
    @(negedge clk256) reset = 1'b1;
    #1;
    chk("t5_rst_all", {entry_active, entry_alarm, digit_cnt, load_time, load_alarm, entry_err, entry_abort, 7'd0}, 16'd0);
    chk("t5_rst_hhmm", {hh_bcd, mm_bcd}, 16'd0);
    chk("t5_rst_bcd", entry_bcd, 16'd0);
    @(negedge clk256) reset = 1'b0;
    entry(`KP_MINUS, `KP_0, `KP_9, `KP_1, `KP_5);
    settle();
    chk("t5_lt_once", 16'(n_lt), 16'd1);
    chk("t5_hhmm", {hh_bcd, mm_bcd}, 16'h0915);

`ifdef KEY_ENTRY_TIMEOUT_EN
    clr_counts();
    press(`KP_STAR); press(`KP_1);
    repeat (1279) @(negedge clk256);
    chk("to_before", {14'd0, entry_active, entry_abort}, 16'h0002);
    @(negedge clk256);
    chk("to_abort", {14'd0, entry_active, entry_abort}, 16'h0001);
    chk("to_cnt0", {13'd0, digit_cnt}, 16'd0);
    settle();
    chk("to_once", 16'(n_ab), 16'd1);
    chk("to_no_load", 16'(n_lt + n_la + n_err), 16'd0);
    clr_counts();
    press(`KP_STAR); press(`KP_1);
    repeat (1279) @(negedge clk256);
    key = `KP_2;
    @(negedge clk256) key = 8'd0;
    chk("to_press_wins", {12'd0, entry_active, digit_cnt}, 16'h000A);
    repeat (20) @(negedge clk256);
    chk("to_no_abort", 16'(n_ab), 16'd0);
`else
    clr_counts();
    press(`KP_STAR); press(`KP_1);
    repeat (1400) @(negedge clk256);
    chk("nto_still_active", {12'd0, entry_active, digit_cnt}, 16'h0009);
    chk("nto_no_abort", 16'(n_ab), 16'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  always @(negedge clk256) begin
    if (!reset) begin
      checks++;
      assert (int'(load_time) + int'(load_alarm) + int'(entry_err) + int'(entry_abort) <= 1) else begin
        errors++;
        $error("FAIL strobe_excl: got %b expected at most one high", {load_time, load_alarm, entry_err, entry_abort});
      end
    end
  end
endmodule
